// File: rtl/maindec_pkg.sv
// maindec_pkg: shared types and encodings for the multicycle MIPS main decoder.
//   state_t   - 4-bit controller state, FETCH=0 .. EXCEPT=13
//   OP_*      - instruction opcodes that the decoder recognises
//   ALUOP_*, PCSRC_*, REGDST_*, MEMTOREG_*, ALUSRCB_* - datapath mux/op encodings
//   ctrl_t    - bundle of every datapath control driven by the decoder
package maindec_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_EXCEPT = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_FUNCT = 3'd2;
  localparam logic [2:0] ALUOP_AND   = 3'd3;
  localparam logic [2:0] ALUOP_OR    = 3'd4;
  localparam logic [2:0] ALUOP_SLT   = 3'd5;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXCVEC = 2'b11;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_DATA   = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_SHIMM = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       bne;
    logic       iord;
    logic       zeroext;
    logic       mem_req;
    logic       illegal_op;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  // Immediate-form ALU instructions share the IEXEC/IWB path.
  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  // ALU operation for the immediate forms; anything else falls back to add.
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    logic [2:0] v;
    v = ALUOP_ADD;
    case (op)
      OP_ANDI: v = ALUOP_AND;
      OP_ORI:  v = ALUOP_OR;
      OP_SLTI: v = ALUOP_SLT;
      default: v = ALUOP_ADD;
    endcase
    return v;
  endfunction

  // Logical immediates are zero-extended, arithmetic ones sign-extended.
  function automatic logic imm_zeroext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/maindec_ext_outdec.sv
// maindec_ext_outdec: combinational control table for the main decoder.
//   i_state - current controller state
//   i_op    - instruction opcode (only looked at in IEXEC and BRANCH)
//   i_rdy   - memory ready, already qualified by the handshake setting
//   o_ctrl  - full datapath control bundle
// Outputs are pure decodes of the state except the FETCH write enables, which
// follow i_rdy so PC and IR only load on the cycle the fetch completes.
module maindec_ext_outdec
  import maindec_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_op,
  input  logic        i_rdy,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_FOUR;
        o_ctrl.irwrite = i_rdy;
        o_ctrl.pcwrite = i_rdy;
      end
      S_DECODE: begin
        o_ctrl.alusrcb = ALUSRCB_SHIMM;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.iord    = 1'b1;
        o_ctrl.mem_req = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = MEMTOREG_DATA;
      end
      S_MEMWR: begin
        // memwrite stays high for the whole stall so the store is held.
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = REGDST_RD;
      end
      S_IEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_IMM;
        o_ctrl.aluop   = imm_aluop(i_op);
        o_ctrl.zeroext = imm_zeroext(i_op);
      end
      S_IWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = REGDST_RT;
        o_ctrl.memtoreg = MEMTOREG_ALUOUT;
      end
      S_BRANCH: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.branch  = 1'b1;
        o_ctrl.bne     = (i_op == OP_BNE);
        o_ctrl.pcsrc   = PCSRC_ALUOUT;
        o_ctrl.aluop   = ALUOP_SUB;
      end
      S_JUMP: begin
        o_ctrl.pcwrite = 1'b1;
        o_ctrl.pcsrc   = PCSRC_JUMP;
      end
      S_JAL: begin
        o_ctrl.pcwrite  = 1'b1;
        o_ctrl.pcsrc    = PCSRC_JUMP;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = REGDST_R31;
        o_ctrl.memtoreg = MEMTOREG_PC;
      end
      S_EXCEPT: begin
        // EXCEPT lasts exactly one cycle, so illegal_op is a single pulse.
        o_ctrl.pcwrite    = 1'b1;
        o_ctrl.pcsrc      = PCSRC_EXCVEC;
        o_ctrl.illegal_op = 1'b1;
      end
      default: begin
        // Unused encodings look like an idle FETCH with no writes.
        o_ctrl.mem_req = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_FOUR;
      end
    endcase
  end

endmodule

// File: rtl/maindec_ext.sv
// maindec_ext: multicycle MIPS main controller (state register + next state).
//   clk        - rising-edge clock
//   reset      - synchronous active-low reset, returns the FSM to FETCH
//   op         - instruction opcode from the IR
//   mem_ready  - memory access completes this cycle
//   pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord,
//   zeroext, mem_req, memtoreg, regdst, alusrcb, pcsrc, aluop - datapath controls
//   illegal_op - one-cycle pulse when an undefined opcode is trapped
//   state_o    - current state for debug
// Parameters: ALUOP_W (>=3, upper bits zero), MEM_HS (honour mem_ready),
// EXC_EN (trap undefined opcodes instead of silently refetching).
//
// state  | meaning
// FETCH  | read instruction, PC+4; waits for memory
// DECODE | register read, branch target into ALUOut
// MEMADR | load/store address calculation
// MEMRD  | load data read; waits for memory
// MEMWB  | load data written to rt
// MEMWR  | store data write; waits for memory
// EXEC   | R-type ALU operation
// ALUWB  | R-type result written to rd
// BRANCH | BEQ/BNE compare and conditional PC load
// IEXEC  | immediate ALU operation
// IWB    | immediate result written to rt
// JUMP   | PC loaded with jump target
// JAL    | jump target into PC, return address into r31
// EXCEPT | undefined opcode, PC loaded with exception vector
module maindec_ext
  import maindec_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter bit MEM_HS  = 1'b1,
  parameter bit EXC_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               branch,
  output logic               bne,
  output logic               iord,
  output logic               zeroext,
  output logic               mem_req,
  output logic [1:0]         memtoreg,
  output logic [1:0]         regdst,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic [3:0]         state_o
);

  state_t r_state;
  state_t w_next;
  logic   w_rdy;
  ctrl_t  w_ctrl;

  // Without the handshake every memory access is assumed to finish at once.
  assign w_rdy = MEM_HS ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW))        w_next = S_MEMADR;
        else if (op == OP_RTYPE)                   w_next = S_EXEC;
        else if ((op == OP_BEQ) || (op == OP_BNE)) w_next = S_BRANCH;
        else if (is_imm_alu(op))                   w_next = S_IEXEC;
        else if (op == OP_J)                       w_next = S_JUMP;
        else if (op == OP_JAL)                     w_next = S_JAL;
        else                                       w_next = EXC_EN ? S_EXCEPT : S_FETCH;
      end
      S_MEMADR: begin
        // op is re-examined here; anything but a load or store abandons the access.
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD:  w_next = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_IEXEC:  w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  maindec_ext_outdec u_outdec (
    .i_state (r_state),
    .i_op    (op),
    .i_rdy   (w_rdy),
    .o_ctrl  (w_ctrl)
  );

  assign pcwrite    = w_ctrl.pcwrite;
  assign memwrite   = w_ctrl.memwrite;
  assign irwrite    = w_ctrl.irwrite;
  assign regwrite   = w_ctrl.regwrite;
  assign alusrca    = w_ctrl.alusrca;
  assign branch     = w_ctrl.branch;
  assign bne        = w_ctrl.bne;
  assign iord       = w_ctrl.iord;
  assign zeroext    = w_ctrl.zeroext;
  assign mem_req    = w_ctrl.mem_req;
  assign memtoreg   = w_ctrl.memtoreg;
  assign regdst     = w_ctrl.regdst;
  assign alusrcb    = w_ctrl.alusrcb;
  assign pcsrc      = w_ctrl.pcsrc;
  assign aluop      = ALUOP_W'(w_ctrl.aluop);
  assign illegal_op = w_ctrl.illegal_op;
  assign state_o    = r_state;

endmodule

// File: tb/tb_maindec_ext.sv
// Bench for maindec_ext. Three instances share clk/reset/op:
//   0: defaults, 1: EXC_EN=0, 2: MEM_HS=0 with mem_ready tied low and ALUOP_W=4.
// The reference model walks the instruction's state path and looks up the
// expected control bundle for each state from the control table.
module tb_maindec_ext;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_IEXEC = 9;
  localparam int S_IWB = 10, S_JUMP = 11, S_JAL = 12, S_EXCEPT = 13;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RTYPE = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011;

  // {pcwrite,memwrite,irwrite,regwrite,alusrca,branch,bne,iord,zeroext,
  //  mem_req,illegal_op,memtoreg[2],regdst[2],alusrcb[2],pcsrc[2],aluop[4]}
  localparam logic [22:0] RESET_CTRL = 23'h002040;

  typedef int q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;

  logic [22:0] ctrl_v [3];
  logic [3:0]  st_v   [3];

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  logic [5:0] ops_tab [11] = '{LW, SW, RTYPE, BEQ, BNE, ADDI, ANDI, ORI, SLTI, J, JAL};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW = (g == 2) ? 4 : 3;
    logic pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord;
    logic zeroext, mem_req, illegal_op;
    logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
    logic [AW-1:0] aluop;
    logic [3:0] state_o;

    maindec_ext #(.ALUOP_W(AW), .MEM_HS(g != 2), .EXC_EN(g != 1)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .mem_ready  ((g == 2) ? 1'b0 : mem_ready),
      .pcwrite    (pcwrite),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .branch     (branch),
      .bne        (bne),
      .iord       (iord),
      .zeroext    (zeroext),
      .mem_req    (mem_req),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .aluop      (aluop),
      .illegal_op (illegal_op),
      .state_o    (state_o)
    );

    assign ctrl_v[g] = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord,
                        zeroext, mem_req, illegal_op, memtoreg, regdst, alusrcb, pcsrc,
                        4'(aluop)};
    assign st_v[g] = state_o;
  end

  // Sequence of states an instruction visits, ignoring stall repeats.
  function automatic q_t path_of(input logic [5:0] o, input bit exc_en);
    q_t p;
    p = {};
    p.push_back(S_FETCH);
    p.push_back(S_DECODE);
    case (o)
      LW:                     begin p.push_back(S_MEMADR); p.push_back(S_MEMRD); p.push_back(S_MEMWB); end
      SW:                     begin p.push_back(S_MEMADR); p.push_back(S_MEMWR); end
      RTYPE:                  begin p.push_back(S_EXEC); p.push_back(S_ALUWB); end
      BEQ, BNE:               p.push_back(S_BRANCH);
      ADDI, ANDI, ORI, SLTI:  begin p.push_back(S_IEXEC); p.push_back(S_IWB); end
      J:                      p.push_back(S_JUMP);
      JAL:                    p.push_back(S_JAL);
      default:                if (exc_en) p.push_back(S_EXCEPT);
    endcase
    return p;
  endfunction

  function automatic logic [22:0] exp_ctrl(input int st, input logic [5:0] o, input logic rdy);
    logic pw, mw, iw, rw, asa, br, bn, io, ze, mr, il;
    logic [1:0] mtr, rd, asb, ps;
    logic [3:0] ao;
    {pw, mw, iw, rw, asa, br, bn, io, ze, mr, il} = '0;
    {mtr, rd, asb, ps} = '0;
    ao = 4'd0;
    case (st)
      S_FETCH:  begin mr = 1; asb = 2'b01; pw = rdy; iw = rdy; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin io = 1; mr = 1; end
      S_MEMWB:  begin rw = 1; mtr = 2'b01; end
      S_MEMWR:  begin io = 1; mr = 1; mw = 1; end
      S_EXEC:   begin asa = 1; ao = 4'd2; end
      S_ALUWB:  begin rw = 1; rd = 2'b01; end
      S_BRANCH: begin asa = 1; br = 1; ps = 2'b01; ao = 4'd1; bn = (o == BNE); end
      S_IEXEC:  begin
        asa = 1; asb = 2'b10;
        ao = (o == ANDI) ? 4'd3 : (o == ORI) ? 4'd4 : (o == SLTI) ? 4'd5 : 4'd0;
        ze = (o == ANDI) || (o == ORI);
      end
      S_IWB:    rw = 1;
      S_JUMP:   begin pw = 1; ps = 2'b10; end
      S_JAL:    begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; end
      S_EXCEPT: begin pw = 1; ps = 2'b11; il = 1; end
      default:  begin mr = 1; asb = 2'b01; end
    endcase
    return {pw, mw, iw, rw, asa, br, bn, io, ze, mr, il, mtr, rd, asb, ps, ao};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Runs one instruction on instance 'sel' from FETCH. fs/ms are the numbers of
  // not-ready cycles in FETCH and in MEMRD/MEMWR. op is randomised in states
  // where the decoder must not look at it.
  task automatic run_instr(input logic [5:0] o, input int fs, input int ms, input string tag);
    q_t p;
    p = path_of(o, sel != 1);
    foreach (p[i]) begin
      int st;
      int stalls;
      bit memst;
      logic rdy;
      logic [22:0] ex;
      st = p[i];
      memst = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
      stalls = 0;
      if (sel != 2) stalls = (st == S_FETCH) ? fs : memst ? ms : 0;
      for (int k = 0; k <= stalls; k++) begin
        if (memst && sel != 2) mem_ready = (k == stalls);
        else                   mem_ready = 1'($urandom_range(0, 1));
        if (st == S_DECODE || st == S_MEMADR || st == S_IEXEC || st == S_BRANCH) op = o;
        else op = 6'($urandom);
        rdy = (sel == 2) ? 1'b1 : mem_ready;
        ex = exp_ctrl(st, o, rdy);
        @(negedge clk);
        n_tests++;
        if (st_v[sel] !== 4'(st)) begin
          n_fail++;
          $display("FAIL %s state (dut%0d op=%b): got %0d want %0d", tag, sel, o, st_v[sel], st);
        end
        n_tests++;
        if (ctrl_v[sel] !== ex) begin
          n_fail++;
          $display("FAIL %s ctrl (dut%0d op=%b st=%0d): got %h want %h", tag, sel, o, st, ctrl_v[sel], ex);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    op = 6'($urandom);
    tick();
    tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      logic [22:0] ex;
      ex = (g == 2) ? exp_ctrl(S_FETCH, op, 1'b1) : RESET_CTRL;
      n_tests++;
      if (st_v[g] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %0d want 0", g, st_v[g]);
      end
      n_tests++;
      if (ctrl_v[g] !== ex) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: got %h want %h", g, ctrl_v[g], ex);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_lw();
    sel = 0;
    do_reset();
    run_instr(LW, 0, 0, "lw");
    run_instr(LW, 0, 0, "lw2");
    mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (st_v[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_done: got state %0d want 0", st_v[0]);
    end
    tick();
  endtask

  task automatic test_sw_stall();
    sel = 0;
    do_reset();
    run_instr(SW, 0, 3, "sw_stall");
  endtask

  task automatic test_fetch_stall();
    sel = 0;
    do_reset();
    run_instr(RTYPE, 2, 0, "fetch_stall");
  endtask

  task automatic test_imm_branch();
    sel = 0;
    do_reset();
    run_instr(ORI, 0, 0, "ori");
    run_instr(BNE, 1, 0, "bne");
    run_instr(ANDI, 0, 0, "andi");
    run_instr(SLTI, 0, 0, "slti");
    run_instr(ADDI, 0, 0, "addi");
    run_instr(BEQ, 0, 0, "beq");
  endtask

  task automatic test_jal_exc();
    sel = 0;
    do_reset();
    run_instr(JAL, 0, 0, "jal");
    run_instr(6'b111111, 0, 0, "except");
    run_instr(J, 0, 0, "j");
    sel = 1;
    do_reset();
    run_instr(6'b111111, 0, 0, "noexc");
    run_instr(6'b010001, 1, 0, "noexc2");
    run_instr(LW, 0, 1, "noexc_lw");
  endtask

  task automatic test_reset_midstall();
    sel = 0;
    do_reset();
    op = LW;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (st_v[0] !== 4'd3) begin
      n_fail++;
      $display("FAIL midstall_pre: got state %0d want 3", st_v[0]);
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (st_v[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL midstall_state: got %0d want 0", st_v[0]);
    end
    n_tests++;
    if (ctrl_v[0] !== RESET_CTRL) begin
      n_fail++;
      $display("FAIL midstall_ctrl: got %h want %h", ctrl_v[0], RESET_CTRL);
    end
    reset = 1'b1;
  endtask

  task automatic test_nohs();
    sel = 2;
    do_reset();
    run_instr(LW, 2, 2, "nohs_lw");
    run_instr(SW, 2, 2, "nohs_sw");
    run_instr(SLTI, 0, 0, "nohs_slti");
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      repeat (30) begin
        logic [5:0] o;
        if ($urandom_range(0, 3) != 0) o = ops_tab[$urandom_range(0, 10)];
        else                           o = 6'($urandom);
        run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    op = 6'd0;
    mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_fetch_stall();
    test_imm_branch();
    test_jal_exc();
    test_reset_midstall();
    test_nohs();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/maindec_ext.md
Name: maindec_ext

Overview:
- Next-generation multicycle MIPS main controller FSM.
- Adds ANDI, ORI, SLTI, BNE and JAL, plus a memory ready handshake that stalls memory states.
- Adds an illegal-opcode exception path and a widened ALU-op encoding.
- Sits in the controller beside aludec. Receives op from the datapath and drives all datapath enables and muxes.

Parameters:
- ALUOP_W, 3: width of aluop. Must be ≥3; upper bits are zero.
- MEM_HS, 1: 1 = honour mem_ready; 0 = mem_ready is treated as constant 1.
- EXC_EN, 1: 1 = undefined opcode goes to EXCEPT; 0 = goes to FETCH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- op  in  6  instruction opcode.
- mem_ready  in  1  memory access complete this cycle.
- pcwrite, memwrite, irwrite, regwrite  out  1 each  write enables.
- alusrca, branch, bne, iord, zeroext, mem_req  out  1 each  datapath controls.
- memtoreg  out  2  00 ALUOut, 01 Data, 10 PC (for JAL).
- regdst  out  2  00 rt, 01 rd, 10 r31.
- alusrcb  out  2  00 B, 01 const 4, 10 SignImm/ZeroImm, 11 shifted imm.
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target, 11 exception vector.
- aluop  out  ALUOP_W  0 add, 1 sub, 2 funct, 3 and, 4 or, 5 slt.
- illegal_op  out  1  one-cycle pulse on entry to EXCEPT.
- state_o  out  4  current state, for debug.

Behaviour:
- State register: reset==0 at a rising edge loads FETCH. This is also the required behaviour when reset arrives mid-instruction, including during a memory stall.
- Outputs are Moore decodes of state, except fetch gating and memory stalls described below.
- Reset state (FETCH) outputs: every output is 0 except alusrcb=01 and mem_req=1.
- "rdy" below means mem_ready when MEM_HS=1, and constant 1 when MEM_HS=0.
- Transitions:
  - FETCH: stays until rdy, then DECODE.
  - DECODE:
    - LW/SW → MEMADR
    - RTYPE → EXEC
    - BEQ/BNE → BRANCH
    - ADDI/ANDI/ORI/SLTI → IEXEC
    - J → JUMP
    - JAL → JAL
    - other → EXCEPT (EXC_EN=1) or FETCH (EXC_EN=0)
  - MEMADR: LW → MEMRD; SW → MEMWR.
  - MEMRD: stays until rdy, then MEMWB.
  - MEMWR: stays until rdy, then FETCH.
  - EXEC → ALUWB.
  - IEXEC → IWB.
  - MEMWB, ALUWB, IWB, BRANCH, JUMP, JAL, EXCEPT → FETCH.
  - Unused encodings → FETCH.
- Outputs that are asserted in each state (all unlisted outputs are 0):
  - FETCH: mem_req=1, alusrcb=01. irwrite and pcwrite equal rdy, so PC and IR update only on the completing cycle.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca, alusrcb=10.
  - MEMRD: iord, mem_req.
  - MEMWB: regwrite, memtoreg=01.
  - MEMWR: iord, mem_req, memwrite. memwrite is held for the whole stall.
  - EXEC: alusrca, aluop=2.
  - ALUWB: regwrite, regdst=01.
  - IEXEC: alusrca, alusrcb=10; aluop by opcode: ADDI→0, ANDI→3, ORI→4, SLTI→5. zeroext=1 for ANDI/ORI.
  - IWB: regwrite, regdst=00, memtoreg=00. zeroext is not required here.
  - BRANCH: alusrca, branch, pcsrc=01, aluop=1. bne=1 when op==BNE.
  - JUMP: pcwrite, pcsrc=10.
  - JAL: pcwrite, pcsrc=10, regwrite, regdst=10, memtoreg=10.
  - EXCEPT: pcwrite, pcsrc=11, illegal_op=1.
- An op change while not in DECODE/MEMADR/IEXEC/BRANCH has no effect. op is sampled only in those states.
- mem_ready asserted outside FETCH/MEMRD/MEMWR is ignored.
- No X on any output in any state, including unused encodings. Unused encodings drive the reset-state outputs.

Decomposition:
- maindec_pkg holds:
  - state enum (4-bit, FETCH=0 … EXCEPT=13)
  - opcode constants: LW, SW, RTYPE, BEQ, BNE=000101, ADDI, ANDI=001100, ORI=001101, SLTI=001010, J, JAL=000011
  - ALUOP_*, PCSRC_*, REGDST_* and MEMTOREG_* encodings
- One sub-module, maindec_ext_outdec: combinational state/op/rdy → control-bundle table. maindec_ext keeps the state register and next-state logic.

Test Plan:
- reset=0 for 2 cycles, then 1, mem_ready=1, op=LW: state sequence 0,1,2,3,4,0. regwrite=1 with memtoreg=01 only in MEMWB; each instruction takes 5 cycles.
- op=SW, mem_ready low for 3 cycles in MEMWR: MEMWR held 4 cycles with memwrite=1 throughout, then FETCH.
- FETCH with mem_ready=0 for 2 cycles: irwrite=pcwrite=0, state stays 0. In the third cycle mem_ready=1 gives irwrite=pcwrite=1, then DECODE.
- op=ORI: IEXEC has aluop=4, zeroext=1, alusrcb=10. IWB has regwrite=1, regdst=00. op=BNE: BRANCH has bne=1, branch=1, aluop=1, pcsrc=01.
- op=JAL: JAL cycle has pcwrite=1, pcsrc=10, regwrite=1, regdst=10, memtoreg=10. op=111111 with EXC_EN=1: EXCEPT with illegal_op pulse, pcsrc=11, then FETCH. With EXC_EN=0: DECODE→FETCH, no pulse.
- reset driven low during a MEMRD stall: next state is FETCH and outputs equal the reset values. With MEM_HS=0 and mem_ready tied 0, LW still completes in 5 cycles.
